rua_run_ctrl: RTL and testbench

Parametrised run controller for the rua core, placed beside the core at the top level. It sequences core reset, counts executed cycles and detects end of program. End of program is one of three events: a store to a `tohost` address, a stalled PC, or a cycle-budget timeout. It reports done, pass/fail, cause and exit code, which lets simulation and FPGA runs finish deterministically instead of after a fixed cycle count.

---
 rtl/rua_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_rua_run_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rua_run_ctrl.sv
// rua_run_ctrl
//   Run controller for the rua core. Holds the core in reset for a fixed
//   number of cycles, then runs it while counting cycles. It stops the run on
//   the first of three end-of-program events: a store to the tohost address,
//   a stalled PC, or the cycle budget running out. The verdict is then frozen
//   until the next reset.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   HOLD  | core held in reset, hold counter running
//   RUN   | core released, cycles counted, exit checks active
//   DONE  | core frozen in reset, verdict outputs held until rst
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   pc         in   current core PC
//   mem_we     in   core data-store strobe
//   mem_addr   in   store address
//   mem_wdata  in   store data
//   core_rst   out  active-high reset to the core
//   running    out  high while in RUN
//   done       out  sticky end-of-program flag
//   pass       out  tohost store with data == 1
//   cause      out  0 none, 1 tohost, 2 stall, 3 timeout
//   exit_code  out  mem_wdata >> 1 of the tohost store, else 0
//   cycles     out  RUN cycles elapsed, saturating
module rua_run_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RESET_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES   = 100,
  parameter int unsigned     STALL_LIMIT  = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_FFF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [1:0]       cause,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycles
);

  // Counters only ever need to reach LIMIT-1, so clog2(LIMIT) bits suffice.
  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned STALL_W = (STALL_LIMIT  > 1) ? $clog2(STALL_LIMIT)  : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic               STALL_EN   = (STALL_LIMIT != 0);
  localparam logic               TMO_EN     = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [XLEN-1:0]    prev_pc;

  logic pc_same;
  logic tohost_hit;
  logic stall_hit;
  logic tmo_hit;

  assign pc_same    = (pc == prev_pc);
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
  // stall_cnt holds the number of equal comparisons already seen, so the
  // current equal comparison is the STALL_LIMIT-th one.
  assign stall_hit  = STALL_EN && pc_same && (stall_cnt == STALL_LAST);
  // The exiting cycle is still counted, so cycles lands exactly on the budget.
  assign tmo_hit    = TMO_EN && (cycles == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      cause     <= 2'd0;
      exit_code <= '0;
      cycles    <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          core_rst <= 1'b1;
          running  <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            core_rst  <= 1'b0;
            running   <= 1'b1;
            cycles    <= '0;
            stall_cnt <= '0;
            prev_pc   <= pc;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_RUN: begin
          prev_pc <= pc;
          if (cycles != '1) begin
            cycles <= cycles + CNT_W'(1);
          end
          if (pc_same) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end else begin
            stall_cnt <= '0;
          end

          if (tohost_hit || stall_hit || tmo_hit) begin
            state    <= S_DONE;
            done     <= 1'b1;
            running  <= 1'b0;
            core_rst <= 1'b1;
          end

          // Priority: tohost, then stall, then timeout. pass and exit_code
          // stay at their reset value of 0 for the non-tohost exits.
          if (tohost_hit) begin
            cause     <= 2'd1;
            pass      <= (mem_wdata == XLEN'(1));
            exit_code <= mem_wdata >> 1;
          end else if (stall_hit) begin
            cause <= 2'd2;
          end else if (tmo_hit) begin
            cause <= 2'd3;
          end
        end

        S_DONE: begin
          core_rst <= 1'b1;
          running  <= 1'b0;
          done     <= 1'b1;
        end

        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rua_run_ctrl.sv
module tb_rua_run_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_FFF0;

  // Instance 0 ("a"): RESET_CYCLES 2, MAX_CYCLES 100, STALL_LIMIT 4, CNT_W 32.
  // Instance 1 ("b"): RESET_CYCLES 3, timeout and stall disabled, CNT_W 8.
  localparam int P_RC  [2] = '{2, 3};
  localparam int P_MAX [2] = '{100, 0};
  localparam int P_SL  [2] = '{4, 0};
  localparam int P_CW  [2] = '{32, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        a_core_rst, a_running, a_done, a_pass;
  logic [1:0]  a_cause;
  logic [31:0] a_exit_code, a_cycles;
  logic        b_core_rst, b_running, b_done, b_pass;
  logic [1:0]  b_cause;
  logic [31:0] b_exit_code;
  logic [7:0]  b_cycles;

  always #5 clk = ~clk;

  rua_run_ctrl #(
    .XLEN(32), .CNT_W(32), .RESET_CYCLES(2), .MAX_CYCLES(100),
    .STALL_LIMIT(4), .TOHOST_ADDR(32'h0000_FFF0)
  ) dut_a (
    .clk(clk), .rst(rst), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(a_core_rst), .running(a_running),
    .done(a_done), .pass(a_pass), .cause(a_cause), .exit_code(a_exit_code),
    .cycles(a_cycles)
  );

  rua_run_ctrl #(
    .XLEN(32), .CNT_W(8), .RESET_CYCLES(3), .MAX_CYCLES(0),
    .STALL_LIMIT(0), .TOHOST_ADDR(32'h0000_FFF0)
  ) dut_b (
    .clk(clk), .rst(rst), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(b_core_rst), .running(b_running),
    .done(b_done), .pass(b_pass), .cause(b_cause), .exit_code(b_exit_code),
    .cycles(b_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: tracks edges since release, equal-PC run length and
  // the verdict, directly from the controller's rules.
  bit              m_inrun [2];
  bit              m_done  [2];
  bit              m_pass  [2];
  int              m_cause [2];
  longint unsigned m_exit  [2];
  longint unsigned m_cyc   [2];
  int              m_rel   [2];
  int              m_eq    [2];
  logic [31:0]     m_last  [2];

  task automatic model_step();
    longint unsigned cmax;
    longint unsigned nxt;
    for (int i = 0; i < 2; i++) begin
      cmax = (64'd1 << P_CW[i]) - 64'd1;
      if (!rst) begin
        m_inrun[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_cause[i] = 0;
        m_exit[i] = 0; m_cyc[i] = 0; m_rel[i] = 0; m_eq[i] = 0; m_last[i] = '0;
      end else if (m_done[i]) begin
        // frozen
      end else if (!m_inrun[i]) begin
        m_rel[i]++;
        if (m_rel[i] == P_RC[i]) begin
          m_inrun[i] = 1; m_cyc[i] = 0; m_eq[i] = 0; m_last[i] = pc;
        end
      end else begin
        nxt = (m_cyc[i] == cmax) ? m_cyc[i] : m_cyc[i] + 1;
        m_eq[i] = (pc == m_last[i]) ? m_eq[i] + 1 : 0;
        m_last[i] = pc;
        m_cyc[i] = nxt;
        if (mem_we && mem_addr == TOHOST) begin
          m_done[i] = 1; m_cause[i] = 1;
          m_pass[i] = (mem_wdata == 32'd1);
          m_exit[i] = (mem_wdata == 32'd1) ? 0 : longint'(mem_wdata / 2);
        end else if (P_SL[i] != 0 && m_eq[i] >= P_SL[i]) begin
          m_done[i] = 1; m_cause[i] = 2;
        end else if (P_MAX[i] != 0 && nxt == longint'(P_MAX[i])) begin
          m_done[i] = 1; m_cause[i] = 3;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(input int i, input string p, input logic cr, input logic rn,
                     input logic dn, input logic ps, input logic [1:0] cs,
                     input logic [31:0] ex, input longint unsigned cy);
    bit live;
    live = m_inrun[i] && !m_done[i];
    chk({p, "core_rst"}, cr, !live);
    chk({p, "running"}, rn, live);
    chk({p, "done"}, dn, m_done[i]);
    chk({p, "pass"}, ps, m_pass[i]);
    chk({p, "cause"}, cs, m_cause[i]);
    chk({p, "exit_code"}, ex, m_exit[i]);
    chk({p, "cycles"}, cy, m_cyc[i]);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, "a_", a_core_rst, a_running, a_done, a_pass, a_cause, a_exit_code, a_cycles);
      cmp(1, "b_", b_core_rst, b_running, b_done, b_pass, b_cause, b_exit_code, b_cycles);
    end
  end

  logic [31:0] pc_v = 32'h0000_1000;

  task automatic drive(input logic [31:0] p, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    pc = p; mem_we = we; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] other_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? 32'h0000_FFF4 : $urandom;
    if (a == TOHOST) a = a ^ 32'h4;
    return a;
  endfunction

  // Changing PC, random stores that never hit tohost.
  task automatic run_free(input int n);
    for (int k = 0; k < n; k++) begin
      pc_v += 4;
      drive(pc_v, 1'($urandom_range(0, 1)), other_addr(), $urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run_free(1);
  endtask

  // Release; after this "a" is in RUN and the next drive is its RUN cycle 0.
  task automatic release_a();
    rst = 1'b1;
    run_free(2);
  endtask

  initial begin
    rst = 1'b0; pc = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    run_free(1);
    chk_en = 1'b1;

    // Reset hold timing
    do_reset();
    chk("rst_core_rst", a_core_rst, 1);
    chk("rst_cycles", a_cycles, 0);
    rst = 1'b1;
    run_free(1);
    chk("hold_edge1_core_rst", a_core_rst, 1);
    chk("hold_edge1_running", a_running, 0);
    run_free(1);
    chk("hold_edge2_core_rst", a_core_rst, 0);
    chk("hold_edge2_running", a_running, 1);
    chk("b_still_held", b_core_rst, 1);

    // tohost pass on RUN cycle 9
    run_free(9);
    pc_v += 4;
    drive(pc_v, 1'b1, TOHOST, 32'd1);
    chk("pass_done", a_done, 1);
    chk("pass_pass", a_pass, 1);
    chk("pass_cause", a_cause, 1);
    chk("pass_exit", a_exit_code, 0);
    chk("pass_cycles", a_cycles, 10);
    for (int k = 0; k < 4; k++) drive(pc_v, 1'b1, TOHOST, $urandom);
    chk("pass_hold_cycles", a_cycles, 10);
    chk("pass_hold_pass", a_pass, 1);
    chk("pass_hold_exit", a_exit_code, 0);

    // Reset mid-RUN aborts
    do_reset();
    release_a();
    run_free(5);
    do_reset();
    chk("abort_core_rst", a_core_rst, 1);
    chk("abort_running", a_running, 0);
    chk("abort_cycles", a_cycles, 0);

    // tohost fail, other address ignored
    release_a();
    run_free(3);
    pc_v += 4;
    drive(pc_v, 1'b1, 32'h0000_FFF4, 32'd7);
    chk("fff4_ignored", a_done, 0);
    run_free(2);
    pc_v += 4;
    drive(pc_v, 1'b1, TOHOST, 32'd7);
    chk("fail_pass", a_pass, 0);
    chk("fail_cause", a_cause, 1);
    chk("fail_exit", a_exit_code, 3);

    // Stall with one PC change before the limit
    do_reset();
    release_a();
    run_free(5);
    drive(pc_v, 1'b0, '0, '0);
    drive(pc_v, 1'b0, '0, '0);
    pc_v += 4;
    drive(pc_v, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) drive(pc_v, 1'b0, '0, '0);
    chk("stall_not_yet", a_done, 0);
    drive(pc_v, 1'b0, '0, '0);
    chk("stall_done", a_done, 1);
    chk("stall_cause", a_cause, 2);
    chk("stall_cycles", a_cycles, 12);
    chk("stall_b_disabled", b_done, 0);

    // Timeout, then disabled timeout on "b" with saturation
    do_reset();
    release_a();
    for (int t = 0; t < 150 && !a_done; t++) run_free(1);
    chk("tmo_done", a_done, 1);
    chk("tmo_cycles", a_cycles, 100);
    chk("tmo_cause", a_cause, 3);
    chk("tmo_pass", a_pass, 0);
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 2) != 0) pc_v += 4;
      drive(pc_v, 1'($urandom_range(0, 1)), other_addr(), $urandom);
    end
    chk("nomax_b_done", b_done, 0);
    chk("nomax_b_cycles_sat", b_cycles, 255);

    // tohost on the final budget cycle wins over timeout
    do_reset();
    release_a();
    run_free(99);
    pc_v += 4;
    drive(pc_v, 1'b1, TOHOST, 32'd1);
    chk("prio_cause", a_cause, 1);
    chk("prio_pass", a_pass, 1);
    chk("prio_cycles", a_cycles, 100);

    // Randomised runs against the model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      rst = 1'b1;
      for (int c = 0; c < 200; c++) begin
        logic        we;
        logic [31:0] a, d;
        rst = ($urandom_range(0, 59) != 0);
        case ($urandom_range(0, 5))
          0, 1:    ;
          2:       pc_v = $urandom;
          default: pc_v += 4;
        endcase
        we = ($urandom_range(0, 3) == 0);
        a  = ($urandom_range(0, 29) == 0) ? TOHOST : other_addr();
        d  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
        drive(pc_v, we, a, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
